vertex_fv_scheduler: RTL
========================

// Module: vertex_fv_scheduler
// PURPOSE
//  Sequences the vertex reservation station into the vertex PEs after the RS fires. Walks the
//  feature-vector index window (start_idx) in Mult_per_PE-wide steps and handshakes each step
//  with the PE array. Flushes the PE pipeline, then pulses complete so the RS can release.
//  Sits between the vertex RS (fire/start_idx/complete) and the vertex PE array (valid/ready).
// PARAMETERS
//  MAX_FV_NUM   16  max feature-vector entries per node held in the RS
//  MULT_PER_PE   2  FV entries consumed per PE step (lanes)
//  PE_LATENCY    3  cycles from accepted step to PE result written; drain length
// PORTS
//  clk          in   1                      clock
//  reset_n      in   1                      async active-low reset
//  fire         in   1                      RS full, window walk may start (1-cycle pulse)
//  fv_len       in   $clog2(MAX_FV_NUM)+1   FV entries per node; sampled on accepted fire
//  pe_ready     in   1                      PE array accepts current step
//  start_idx    out  $clog2(MAX_FV_NUM)     first FV index of current window, to RS
//  pe_valid     out  1                      RS output window valid for PE array
//  lane_mask    out  MULT_PER_PE            per-lane valid; partial on last odd step
//  complete     out  1                      1-cycle pulse: all steps done and drained
//  busy         out  1                      high from accepted fire until complete pulse
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low.
//  Reset: state=IDLE; start_idx=0, pe_valid=0, lane_mask=0, complete=0, busy=0; counters cleared.
//   Reset mid-walk aborts immediately; no complete pulse is issued.
//  Outputs are registered; no combinational path from any input to any output.
//  steps = ceil(fv_len/MULT_PER_PE); fv_len latched on accepted fire; fv_len > MAX_FV_NUM clamps to MAX_FV_NUM.
//  FSM:
//   IDLE : fire -> SETUP, start_idx=0, busy=1. fire with fv_len=0 -> DRAIN (no steps).
//   SETUP: start_idx stable, pe_valid=0 for 1 cycle (RS registers its window) -> ISSUE.
//   ISSUE: pe_valid=1, start_idx/lane_mask held until pe_valid&&pe_ready.
//          On accept: if last step -> DRAIN, else start_idx+=MULT_PER_PE -> SETUP.
//   DRAIN: pe_valid=0; count PE_LATENCY cycles -> DONE.
//   DONE : complete=1 for exactly one cycle, busy=0 -> IDLE.
//  lane_mask: all ones except on the last step, where lane k=1 iff start_idx+k < fv_len.
//  fire while busy is ignored (no restart, no queueing). fire in the DONE cycle is also ignored.
//  pe_ready while pe_valid=0 has no effect. pe_ready may stall ISSUE indefinitely.
//  Minimum latency fire->complete = 1 + steps*2 + PE_LATENCY + 1 cycles with pe_ready tied high.
//  start_idx arithmetic is done at width+1; the walk never wraps past MAX_FV_NUM-1.
// CONFIGURATION
//  VTX_SCHED_PERF_EN defined: adds outputs perf_walk_cycles[31:0] (cycles busy, last walk)
//   and perf_stall_cycles[31:0] (cycles pe_valid&&!pe_ready, last walk). Both are cleared
//   on accepted fire, saturate at all-ones, and hold after complete. Both reset to 0.
//  Undefined: the ports and counters are absent. Core behaviour is identical either way.
// STRUCTURE
//  Shared package: sched_state_t enum (IDLE,SETUP,ISSUE,DRAIN,DONE); MAX_FV_NUM/MULT_PER_PE
//   derived index widths, shared with vertex RS and PE.
//  One sub-module: vertex_sched_perf_cnt (saturating counter pair), instantiated only under
//   VTX_SCHED_PERF_EN.
// TESTING
//  1 fv_len=16, MULT=2, pe_ready=1, fire pulse -> start_idx 0,2,..,14 in 8 steps; complete at
//    fire+1+16+3+1=21 cycles; busy high throughout.
//  2 fv_len=5 -> 3 steps; lane_mask 11,11,01 on the last step (start_idx=4).
//  3 pe_ready low for 4 cycles on step 2 -> start_idx/lane_mask held, pe_valid stays 1,
//    complete delayed 4 cycles; perf_stall_cycles=4 (PERF_EN).
//  4 fire asserted again mid-walk and in the DONE cycle -> ignored; exactly one complete.
//  5 fv_len=0 -> no pe_valid; complete at fire+PE_LATENCY+2.
//  6 reset_n low during ISSUE -> all outputs 0 asynchronously; after release, a new fire
//    runs cleanly.

Source files
------------

// File: rtl/vertex_fv_scheduler_pkg.sv
// Shared definitions for the vertex feature-vector scheduler, the vertex
// reservation station and the vertex PE array.
//   MAX_FV_NUM  : max feature-vector entries per node held in the RS
//   MULT_PER_PE : FV entries consumed per PE step (lanes)
//   PE_LATENCY  : cycles from an accepted step to its PE result (drain length)
//   IDX_W/LEN_W : FV index width and FV length width (index width + 1)
package vertex_fv_scheduler_pkg;

  localparam int MAX_FV_NUM  = 16;
  localparam int MULT_PER_PE = 2;
  localparam int PE_LATENCY  = 3;

  localparam int IDX_W   = $clog2(MAX_FV_NUM);
  localparam int LEN_W   = IDX_W + 1;
  localparam int DRAIN_W = $clog2(PE_LATENCY + 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ISSUE,
    DRAIN,
    DONE
  } sched_state_t;

  // Lengths above the RS capacity are treated as a full RS.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len > LEN_W'(MAX_FV_NUM)) ? LEN_W'(MAX_FV_NUM) : len;
  endfunction

  // Lane k is live iff its FV index falls inside the node's FV length.
  // The sum is formed one bit wider than the index so it cannot wrap.
  function automatic logic [MULT_PER_PE-1:0] lane_mask_for(input logic [IDX_W-1:0] idx,
                                                          input logic [LEN_W-1:0] len);
    logic [MULT_PER_PE-1:0] m;
    m = '0;
    for (int k = 0; k < MULT_PER_PE; k++) begin
      m[k] = (({1'b0, idx} + LEN_W'(k)) < len);
    end
    return m;
  endfunction

endpackage

// File: rtl/vertex_sched_perf_cnt.sv
// Saturating counter pair for scheduler walk statistics.
//   clk, reset_n     : clock, async active-low reset (counters go to 0)
//   clear            : zero both counters (new walk accepted); wins over increments
//   walk_inc         : count one busy cycle
//   stall_inc        : count one stalled-handshake cycle
//   walk_cycles      : busy cycles of the current/last walk, saturating
//   stall_cycles     : stall cycles of the current/last walk, saturating
module vertex_sched_perf_cnt (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        walk_inc,
  input  logic        stall_inc,
  output logic [31:0] walk_cycles,
  output logic [31:0] stall_cycles
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      walk_cycles  <= '0;
      stall_cycles <= '0;
    end else if (clear) begin
      walk_cycles  <= '0;
      stall_cycles <= '0;
    end else begin
      if (walk_inc && (walk_cycles != '1)) begin
        walk_cycles <= walk_cycles + 32'd1;
      end
      if (stall_inc && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
    end
  end

endmodule

// File: rtl/vertex_fv_scheduler.sv
// Vertex FV window scheduler. After the RS fires, walks the FV index window
// in MULT_PER_PE-wide steps, handshakes each step with the PE array, drains
// the PE pipeline and pulses complete so the RS can release.
// Optional feature macro: VTX_SCHED_PERF_EN adds perf_walk_cycles and
// perf_stall_cycles outputs.
//   clk, reset_n   : clock, async active-low reset
//   fire           : RS full pulse; starts a walk when idle
//   fv_len         : FV entries per node, latched when fire is accepted
//   pe_ready       : PE array accepts the current step
//   start_idx      : first FV index of the current window, to the RS
//   pe_valid       : window valid for the PE array
//   lane_mask      : per-lane valid for the current window
//   complete       : one-cycle pulse when all steps are done and drained
//   busy           : high from accepted fire until the complete pulse
//   state          : FSM state, for debug/observation
//   perf_*         : walk statistics (VTX_SCHED_PERF_EN only)
//
// Handshake: a step transfers on a rising clk edge where pe_valid && pe_ready.
// While pe_valid is high, start_idx and lane_mask stay constant until that
// transfer; pe_ready is ignored whenever pe_valid is low.
module vertex_fv_scheduler
  import vertex_fv_scheduler_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   fire,
  input  logic [LEN_W-1:0]       fv_len,
  input  logic                   pe_ready,
  output logic [IDX_W-1:0]       start_idx,
  output logic                   pe_valid,
  output logic [MULT_PER_PE-1:0] lane_mask,
  output logic                   complete,
  output logic                   busy,
  output sched_state_t           state
`ifdef VTX_SCHED_PERF_EN
  ,
  output logic [31:0]            perf_walk_cycles,
  output logic [31:0]            perf_stall_cycles
`endif
);

  logic [LEN_W-1:0]   len_q;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [LEN_W-1:0]   next_idx;
  logic [LEN_W-1:0]   fire_len;
  logic               last_step;
  logic               fire_accept;

  assign fire_len    = clamp_len(fv_len);
  // Index arithmetic one bit wider than start_idx: the step past the last
  // window is detected by comparison, never by wrap-around.
  assign next_idx    = {1'b0, start_idx} + LEN_W'(MULT_PER_PE);
  assign last_step   = (next_idx >= len_q);
  assign fire_accept = (state == IDLE) && fire;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      start_idx <= '0;
      pe_valid  <= 1'b0;
      lane_mask <= '0;
      complete  <= 1'b0;
      busy      <= 1'b0;
      len_q     <= '0;
      drain_cnt <= '0;
    end else begin
      complete <= 1'b0;
      case (state)
        IDLE: begin
          if (fire) begin
            busy      <= 1'b1;
            start_idx <= '0;
            len_q     <= fire_len;
            drain_cnt <= '0;
            state     <= (fire_len == '0) ? DRAIN : SETUP;
          end
        end
        // One quiet cycle so the RS can register the window at start_idx.
        SETUP: begin
          pe_valid  <= 1'b1;
          lane_mask <= lane_mask_for(start_idx, len_q);
          state     <= ISSUE;
        end
        ISSUE: begin
          if (pe_ready) begin
            pe_valid <= 1'b0;
            if (last_step) begin
              drain_cnt <= '0;
              state     <= DRAIN;
            end else begin
              start_idx <= next_idx[IDX_W-1:0];
              state     <= SETUP;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_W'(PE_LATENCY - 1)) begin
            complete <= 1'b1;
            busy     <= 1'b0;
            state    <= DONE;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        // complete is high for this cycle only; fire here is ignored.
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef VTX_SCHED_PERF_EN
  vertex_sched_perf_cnt u_perf_cnt (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (fire_accept),
    .walk_inc     (busy),
    .stall_inc    (pe_valid && !pe_ready),
    .walk_cycles  (perf_walk_cycles),
    .stall_cycles (perf_stall_cycles)
  );
`else
  logic unused_fire_accept;
  assign unused_fire_accept = fire_accept;
`endif

endmodule
